// File: rtl/seq_divider_if.sv
// Request/result bundle for the sequential signed divider.
// master drives operands and start; slave returns status and results.
interface seq_divider_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Signed restoring divider: one quotient bit per clock on operand magnitudes,
// sign correction applied when the result is registered.
module seq_divider #(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [N-1:0]  q_mag;
    logic [N-1:0]  dsr_mag;
    logic [N-1:0]  rem;
    logic          neg_q;
    logic          neg_r;
    logic          dbz;

    logic          busy_q;
    logic          done_q;
    logic [N-1:0]  quot_q;
    logic [N-1:0]  rem_q;
    logic          dbz_q;

    logic          accept_c;
    logic          last_c;
    logic          zero_dsr_c;
    logic [N-1:0]  dvd_abs_c;
    logic [N-1:0]  dsr_abs_c;
    logic [N:0]    shifted_c;
    logic [N:0]    diff_c;
    logic [N-1:0]  quot_fix_c;
    logic [N-1:0]  rem_fix_c;

    // |-2^(N-1)| wraps back to 2^(N-1), which is exact as an unsigned N-bit value
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x);
        return x[N-1] ? (~x + N'(1)) : x;
    endfunction

    assign accept_c   = (state == IDLE) && bus.start;
    assign last_c     = (cnt == CW'(N - 1));
    assign zero_dsr_c = (bus.divisor == '0);
    assign dvd_abs_c  = magnitude(bus.dividend);
    assign dsr_abs_c  = magnitude(bus.divisor);

    // Partial remainder stays below 2^N, so the N+1 bit difference sign is exact
    assign shifted_c  = {rem, q_mag[N-1]};
    assign diff_c     = shifted_c - {1'b0, dsr_mag};

    assign quot_fix_c = dbz ? '1 : (neg_q ? (~q_mag + N'(1)) : q_mag);
    assign rem_fix_c  = neg_r ? (~rem + N'(1)) : rem;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_c) state_nxt = zero_dsr_c ? FINISH : CALC;
            CALC:    if (last_c) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            q_mag   <= '0;
            dsr_mag <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            dbz     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt != IDLE);
            done_q <= (state == FINISH);
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        q_mag   <= dvd_abs_c;
                        dsr_mag <= dsr_abs_c;
                        // Divide-by-zero returns the dividend through the remainder path
                        rem     <= zero_dsr_c ? dvd_abs_c : '0;
                        neg_q   <= bus.dividend[N-1] ^ bus.divisor[N-1];
                        neg_r   <= bus.dividend[N-1];
                        dbz     <= zero_dsr_c;
                        cnt     <= '0;
                    end
                end
                CALC: begin
                    q_mag <= {q_mag[N-2:0], ~diff_c[N]};
                    rem   <= diff_c[N] ? shifted_c[N-1:0] : diff_c[N-1:0];
                    cnt   <= last_c ? '0 : cnt + CW'(1);
                end
                FINISH: begin
                    quot_q <= quot_fix_c;
                    rem_q  <= rem_fix_c;
                    dbz_q  <= dbz;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (N=8): stimulus pushes hand-computed results
// into a scoreboard queue, a monitor pops and compares on every done pulse.
module tb_seq_divider;
    localparam int N = 8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       z;
        int         done_cyc;
        string      name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];

    seq_divider_if #(.N(N)) bus ();
    seq_divider #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Caller sits at a negedge; start is accepted at the following posedge
    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                         input logic [7:0] r, input logic z, input string nm, input bit push);
        exp_t e;
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        if (push) begin
            e.q        = q;
            e.r        = r;
            e.z        = z;
            e.done_cyc = cyc + 1 + ((b == 8'd0) ? 1 : N + 1);
            e.name     = nm;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((bus.busy || sb.size() != 0) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check({nm, "_timeout"}, 32'(n), 32'd0);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_busy"}, 32'(bus.busy), 32'd0);
        check({nm, "_done"}, 32'(bus.done), 32'd0);
        check({nm, "_q"},    32'(bus.quotient), 32'd0);
        check({nm, "_r"},    32'(bus.remainder), 32'd0);
        check({nm, "_dbz"},  32'(bus.div_by_zero), 32'd0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, "_q"},       32'(bus.quotient), 32'(e.q));
                check({e.name, "_r"},       32'(bus.remainder), 32'(e.r));
                check({e.name, "_dbz"},     32'(bus.div_by_zero), 32'(e.z));
                check({e.name, "_latency"}, 32'(cyc), 32'(e.done_cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        logic [7:0] va [11] = '{8'h9C, 8'h64, 8'h9C, 8'h80, 8'h80, 8'h05, 8'h7F,
                                8'h00, 8'h80, 8'h7F, 8'h25};
        logic [7:0] vb [11] = '{8'h07, 8'hF9, 8'hF9, 8'hFF, 8'h01, 8'h09, 8'h7F,
                                8'hFB, 8'h03, 8'h80, 8'h00};
        logic [7:0] vq [11] = '{8'hF2, 8'hF2, 8'h0E, 8'h80, 8'h80, 8'h00, 8'h01,
                                8'h00, 8'hD6, 8'h00, 8'hFF};
        logic [7:0] vr [11] = '{8'hFE, 8'h02, 8'hFE, 8'h00, 8'h00, 8'h05, 8'h00,
                                8'h00, 8'hFE, 8'h7F, 8'h25};
        logic       vz [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1};
        int n;
        int viol;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");

        // First start accepted on the first edge after reset release
        rst = 1'b0;
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "100/7", 1'b1);
        n = 0;
        while (bus.busy && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("busy_cycles", 32'(n), 32'd9);
        wait_idle("first");

        for (int i = 0; i < 11; i++) begin
            issue(va[i], vb[i], vq[i], vr[i], vz[i], $sformatf("vec%0d", i), 1'b1);
            wait_idle($sformatf("vec%0d", i));
        end

        // Results hold through CALC; a start raised while busy is ignored
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "hold_100/7", 1'b1);
        bus.start    = 1'b1;
        bus.dividend = 8'd50;
        bus.divisor  = 8'd5;
        n    = 0;
        viol = 0;
        while (bus.busy && n < 20) begin
            if (bus.quotient !== 8'hFF || bus.remainder !== 8'h25 || bus.div_by_zero !== 1'b1)
                viol++;
            n++;
            if (n >= N - 1) bus.start = 1'b0;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check("hold_during_calc", 32'(viol), 32'd0);
        wait_idle("hold");

        // Back-to-back: new start issued in the done cycle
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "b2b_first", 1'b1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_seen", 32'(bus.done), 32'd1);
        issue(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, "b2b_second", 1'b1);
        wait_idle("b2b");

        // Reset four cycles into a division aborts it silently
        issue(8'd100, 8'd7, 8'd0, 8'd0, 1'b0, "aborted", 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        issue(8'd100, 8'd7, 8'd14, 8'd2, 1'b0, "post_abort", 1'b1);
        wait_idle("post_abort");
        repeat (12) @(negedge clk);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
